// File: rtl/debounce_pulse_pkg.sv
// Shared types and helpers for the debounce_pulse block: FSM state encoding
// and the counter-width function used by the top level.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // Bits needed to count up to the larger of two limits (inclusive).
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_pulse_sync_chain.sv
// sync_chain: N-flop synchronizer for asynchronous pin inputs, cleared to 0 by
// the asynchronous active-low reset. Shared by other pin-facing blocks.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  // chain[0] is the raw pin, chain[STAGES] the fully synchronized sample.
  logic [STAGES:0] chain;

  assign chain[0] = din;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // One synchronizer flop per stage, shifting the pin value along the chain.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          chain[gi+1] <= 1'b0;
        end else begin
          chain[gi+1] <= chain[gi];
        end
      end
    end
  endgenerate

  assign dout = chain[STAGES];

endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronizes and debounces a bouncing button input, producing
// a clean level plus one-cycle rise/fall pulses. All outputs are registered.
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to emit repeated rise pulses
// every REPEAT_CYCLES cycles while the button stays accepted high.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = clog2_max(STABLE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic            s;
  db_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            level_reg, level_next;
  logic            rise_reg, rise_next;
  logic            fall_reg, fall_next;
  logic            accept_high, accept_low;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (btn_in),
    .dout (s)
  );

  // A change is accepted on the STABLE_CYCLES-th consecutive matching sample.
  assign accept_high = (state_reg == WAIT_HIGH) && s  && (cnt_reg == STABLE_LAST);
  assign accept_low  = (state_reg == WAIT_LOW)  && !s && (cnt_reg == STABLE_LAST);

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_reg, rep_next;
  logic             repeat_fire;

  // Repeat counter only advances while staying in HIGH; it is frozen in WAIT_LOW.
  assign repeat_fire = (state_reg == HIGH) && s && (rep_reg == REPEAT_LAST);
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rep_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rep_reg   <= rep_next;
`endif
    end
  end

  // Next-state and stability-counter logic; counter saturates instead of wrapping.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE_LOW: begin
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (accept_high) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (accept_low) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
`ifdef DEBOUNCE_AUTOREPEAT_EN
    rep_next = rep_reg;
    if (accept_high) begin
      rep_next = '0;
    end else if ((state_reg == HIGH) && s) begin
      rep_next = repeat_fire ? '0 : rep_reg + CNT_ONE;
    end
`endif
  end

  // Output values to register: level moves and pulses fire only on acceptance.
  always_comb begin
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (accept_high) begin
      level_next = 1'b1;
      rise_next  = 1'b1;
    end
    if (accept_low) begin
      level_next = 1'b0;
      fall_next  = 1'b1;
    end
`ifdef DEBOUNCE_AUTOREPEAT_EN
    if (repeat_fire) begin
      rise_next = 1'b1;
    end
`endif
  end

  assign level      = level_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed testbench for debounce_pulse with a pulse scoreboard.
// Honors DEBOUNCE_AUTOREPEAT_EN when the design is built with it.
module tb_debounce_pulse;

  logic clk    = 1'b0;
  logic rstn   = 1'b1;
  logic btn_in = 1'b0;
  logic level, rise_pulse, fall_pulse;

  localparam logic [1:0] RISE = 2'b10;
  localparam logic [1:0] FALL = 2'b01;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } ev_t;

  ev_t sb[$];
  int  cycle = 0;
  int  tests = 0;
  int  fails = 0;

  debounce_pulse #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .REPEAT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_in     (btn_in),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [1:0] kind);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // One clock: count the edge, then sample outputs on the falling edge.
  task automatic step();
    ev_t e;
    @(posedge clk);
    cycle++;
    @(negedge clk);
    if (rise_pulse || fall_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, rise_pulse, fall_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cycle, e.cyc);
        check("pulse_kind", {30'd0, rise_pulse, fall_pulse}, {30'd0, e.kind});
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cycle) begin
      e = sb.pop_front();
      check("missed_pulse", {30'd0, rise_pulse, fall_pulse}, {30'd0, e.kind});
    end
    if (rise_pulse && fall_pulse) begin
      check("pulse_exclusive", {31'd0, rise_pulse & fall_pulse}, 32'd0);
    end
  endtask

  task automatic run_to(input int c);
    while (cycle < c) step();
  endtask

  initial begin
    int k;
    int m;

    // Reset state
    #2 rstn = 1'b0;
    #1;
    check("reset_level", {31'd0, level}, 32'd0);
    check("reset_rise", {31'd0, rise_pulse}, 32'd0);
    check("reset_fall", {31'd0, fall_pulse}, 32'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    step();
    check("post_reset_level", {31'd0, level}, 32'd0);

    // 1/4. Clean press then release: pulses 6 edges after each change
    k = cycle;
    btn_in = 1'b1;
    expect_pulse(k + 6, RISE);
    run_to(k + 5);
    check("t1_level_pre", {31'd0, level}, 32'd0);
    step();
    check("t1_level_high", {31'd0, level}, 32'd1);
    btn_in = 1'b0;
    k = cycle;
    expect_pulse(k + 6, FALL);
    run_to(k + 5);
    check("t4_level_pre", {31'd0, level}, 32'd1);
    step();
    check("t4_level_low", {31'd0, level}, 32'd0);
    run_to(cycle + 3);

    // 3. Glitch: 3-cycle high pulse is rejected
    k = cycle;
    btn_in = 1'b1;
    step(); step(); step();
    btn_in = 1'b0;
    run_to(k + 12);
    check("t3_glitch_level", {31'd0, level}, 32'd0);

    // Boundary: 4-cycle high pulse is just long enough
    k = cycle;
    btn_in = 1'b1;
    expect_pulse(k + 6, RISE);
    step(); step(); step(); step();
    btn_in = 1'b0;
    expect_pulse(k + 10, FALL);
    run_to(k + 6);
    check("b4_level_high", {31'd0, level}, 32'd1);
    run_to(k + 14);
    check("b4_level_low", {31'd0, level}, 32'd0);

    // 2. Bounce: 1,0,1,0,1,0 then steady 1
    for (int i = 0; i < 6; i++) begin
      btn_in = (i % 2 == 0);
      step();
    end
    btn_in = 1'b1;
    k = cycle;
    expect_pulse(k + 6, RISE);
    run_to(k + 5);
    check("t2_level_pre", {31'd0, level}, 32'd0);
    step();
    check("t2_level_high", {31'd0, level}, 32'd1);
    btn_in = 1'b0;
    k = cycle;
    expect_pulse(k + 6, FALL);
    run_to(k + 9);

    // 5. Reset during WAIT_HIGH aborts qualification; held input re-qualifies
    btn_in = 1'b1;
    step(); step(); step();
    rstn = 1'b0;
    #1;
    check("t5_rst_level", {31'd0, level}, 32'd0);
    check("t5_rst_rise", {31'd0, rise_pulse}, 32'd0);
    step(); step();
    rstn = 1'b1;
    m = cycle;
    expect_pulse(m + 6, RISE);
    run_to(m + 6);
    check("t5_level_high", {31'd0, level}, 32'd1);

    // Reset while level is high clears it at once; held input re-qualifies
    rstn = 1'b0;
    #1;
    check("t5_rst_level_async", {31'd0, level}, 32'd0);
    step();
    rstn = 1'b1;
    m = cycle;
    expect_pulse(m + 6, RISE);
    run_to(m + 6);
    check("t5_requal_level", {31'd0, level}, 32'd1);
    btn_in = 1'b0;
    k = cycle;
    expect_pulse(k + 6, FALL);
    run_to(k + 9);

    // 6. Long hold: repeats at +8/+16/+24 only when auto-repeat is built in
    k = cycle;
    btn_in = 1'b1;
    expect_pulse(k + 6, RISE);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    expect_pulse(k + 14, RISE);
    expect_pulse(k + 22, RISE);
    expect_pulse(k + 30, RISE);
`endif
    run_to(k + 32);
    check("t6_level_held", {31'd0, level}, 32'd1);
    btn_in = 1'b0;
    expect_pulse(k + 38, FALL);
    run_to(k + 42);
    check("t6_level_low", {31'd0, level}, 32'd0);

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
